// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared state encoding, default multiplier latency and operand magnitude helper
package mips_muldiv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;
  localparam int DEF_MUL_LATENCY = 33;
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO register pair with per-register write enables
// Ports: Clock, Reset_n (async, active-low); we_hi/we_lo write strobes; d_hi/d_lo write data; hi/lo register view.
// Build option HILO_FWD_EN: hi/lo forward d_hi/d_lo combinationally in the cycle they are written.
module hilo_regs (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] d_hi,
  input  logic [31:0] d_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [31:0] hi_q, lo_q;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (we_hi) hi_q <= d_hi;
      if (we_lo) lo_q <= d_lo;
    end
`ifdef HILO_FWD_EN
  assign hi = we_hi ? d_hi : hi_q;
  assign lo = we_lo ? d_lo : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif
endmodule

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: sequences MULT/MULTU through an external shift-add multiplier into HI/LO, plus MTHI/MTLO
// Ports: Clock, Reset_n (async, active-low); start/is_signed/rs_val/rt_val multiply request;
//   mthi/mtlo/wdata register moves; mul_result from multiplier; mul_load/mul_a/mul_b to multiplier;
//   hi/lo architectural registers; busy stall request; done one-cycle completion pulse.
// Build option HILO_FWD_EN (in hilo_regs): same-cycle forwarding of HI/LO writes.
module hilo_mult_ctrl
  import mips_muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int CNT_W       = 6
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [63:0] mul_result,
  output logic        mul_load,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  state_t state, nxt;
  logic [CNT_W-1:0] count;
  logic neg, cap, mt_ok;
  logic [63:0] prod;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? RUN :
          state == RUN  ? (count == CNT_W'(MUL_LATENCY - 1) ? CAPTURE : RUN) :
          IDLE;
  end
  assign busy     = state != IDLE;
  assign mul_load = state != RUN;
  assign cap      = state == CAPTURE;
  // start wins over a register move issued in the same idle cycle
  assign mt_ok    = state == IDLE && !start;
  // multiplier works on magnitudes; the sign is restored on capture
  assign prod     = neg ? -mul_result : mul_result;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      mul_a <= '0;
      mul_b <= '0;
      neg   <= 1'b0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done  <= cap;
      count <= state == RUN ? count + 1'b1 : '0;
      if (state == IDLE && start) begin
        mul_a <= is_signed ? abs32(rs_val) : rs_val;
        mul_b <= is_signed ? abs32(rt_val) : rt_val;
        neg   <= is_signed & (rs_val[31] ^ rt_val[31]);
      end
    end
  hilo_regs u_regs (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .we_hi  (cap | (mt_ok & mthi)),
    .we_lo  (cap | (mt_ok & mtlo)),
    .d_hi   (cap ? prod[63:32] : wdata),
    .d_lo   (cap ? prod[31:0] : wdata),
    .hi     (hi),
    .lo     (lo)
  );
endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
Sequencer that sits between the MIPS control unit and the shift-add multiplier (mul). It accepts MULT/MULTU requests and converts signed operands to magnitudes. It drives the multiplier's load/operand inputs, waits the fixed multiplier latency, then applies sign correction and writes the 64-bit product into the architectural HI/LO registers. It also services MTHI/MTLO, exposes HI/LO for MFHI/MFLO, and asserts busy so the control unit can stall.

Parameters:
MUL_LATENCY, 33, RUN-state cycles from first mul_load=0 cycle until mul_result holds the final product.
CNT_W, 6, width of internal latency counter; must hold MUL_LATENCY.

Ports:
Clock  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
start  input  1  request multiply; sampled only in IDLE.
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
rs_val  input  32  operand A (to multiplicando).
rt_val  input  32  operand B (to multiplicador).
mthi  input  1  write wdata to HI.
mtlo  input  1  write wdata to LO.
wdata  input  32  MTHI/MTLO data.
mul_result  input  64  product from multiplier.
mul_load  output  1  multiplier clear/hold.
mul_a  output  32  multiplicando to multiplier.
mul_b  output  32  multiplicador to multiplier.
hi  output  32  HI register.
lo  output  32  LO register.
busy  output  1  multiply in flight; control unit stalls.
done  output  1  one-cycle pulse, HI/LO just updated by a multiply.

Behaviour:
- Reset (Reset_n=0, async): state=IDLE; hi=lo=0; busy=0; done=0; mul_a=mul_b=0; count=0; neg flag=0. mul_load=1.
- States: IDLE, LOAD, RUN, CAPTURE. All outputs are registered or decoded from state.
- IDLE: mul_load=1, busy=0.
  - On start=1: latch mul_a=|rs_val| and mul_b=|rt_val| (magnitudes if is_signed, raw otherwise). Latch neg = is_signed & (rs_val[31]^rt_val[31]). Go to LOAD.
  - Magnitude of 0x80000000 is 0x80000000 (unsigned).
- LOAD: one cycle. mul_load=1, busy=1. Operands stable. count=0. Go to RUN.
- RUN: mul_load=0, busy=1. count increments each cycle. When count==MUL_LATENCY-1, go to CAPTURE.
- CAPTURE: busy=1, mul_load=1. At the exiting edge: {hi,lo} = neg ? -mul_result (64-bit two's complement) : mul_result. done=1 for the next cycle. Go to IDLE.
- mul_a/mul_b are held constant from IDLE exit until return to IDLE.
- Latency: start sampled at edge E. HI/LO and done are visible after edge E+MUL_LATENCY+2, i.e. MUL_LATENCY+2 cycles of busy.
- MTHI/MTLO: honoured only in IDLE with start=0; registered write at next edge. Both asserted together writes both.
  - Ignored while busy.
  - Ignored if start=1 in the same cycle: start has priority.
- start while busy: ignored; no queuing.
- Reset mid-operation: abort immediately to IDLE. HI/LO are cleared; the partial product is discarded.
- done is never asserted for MTHI/MTLO.

Optional Feature:
HILO_FWD_EN:
- Defined: hi/lo outputs are combinational forwards. In a cycle where an MTHI/MTLO write is accepted, hi (resp. lo) shows wdata. In the CAPTURE cycle, {hi,lo} show the corrected product. MFHI issued in that cycle needs no extra stall.
- Undefined: hi/lo are pure register outputs; new values appear one cycle after the write.

Decomposition:
- Shared package mips_muldiv_pkg holds:
  - the state enum typedef (IDLE, LOAD, RUN, CAPTURE);
  - the localparam default MUL_LATENCY;
  - a function abs32 (magnitude of a two's-complement word).
- One sub-module, hilo_regs: the HI/LO register pair with write enables and the optional forward mux. The FSM lives in hilo_mult_ctrl.
- The multiplier itself stays external; the bench instantiates mul alongside.

Test Plan:
- Reset then idle: Reset_n low mid-cycle -> hi=lo=0, busy=0, mul_load=1 immediately (async).
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy for MUL_LATENCY+2 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse one cycle.
- MULT -3*7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- MTHI 0x12345678 in IDLE, then MTLO during busy -> hi=0x12345678, MTLO ignored. start+mthi same cycle -> only the multiply takes effect.
- Reset_n pulsed during RUN of MULTU 5*5 -> state IDLE, hi=lo=0, no done. A subsequent MULTU 5*5 -> lo=25, hi=0.
